// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, forwarding selects,
// jump conditions, CCR bit positions and the EX/MEM control bundle.
package execute_stage_pkg;

    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int FLAG_W = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_MOV  = 4'd1,
        ALU_NOT  = 4'd2,
        ALU_INC  = 4'd3,
        ALU_DEC  = 4'd4,
        ALU_ADD  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_SHL  = 4'd9,
        ALU_SHR  = 4'd10,
        ALU_SETC = 4'd11,
        ALU_CLRC = 4'd12
    } alu_op_t;

    // Select 3 is an alias of the register file path.
    typedef enum logic [1:0] {
        FWD_REG  = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_REG3 = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_Z    = 2'd1,
        JMP_N    = 2'd2,
        JMP_C    = 2'd3
    } jump_cond_t;

    // Control fields carried into the memory stage; zeroed on a flush.
    typedef struct packed {
        logic       memory_read;
        logic       memory_write;
        logic       memory_push;
        logic       memory_pop;
        logic       reg_write;
        logic       pc_enable;
        logic [1:0] memory_address_select;
        logic [1:0] memory_write_src_select;
        logic [1:0] wb_sel;
    } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU: result, candidate flag values and a mask of which
// CCR bits this op is allowed to change.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FW   = 3,
    parameter int SH_W = $clog2(DW)
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  alu_op_t         op,
    input  logic [SH_W-1:0] shamt,
    input  logic            carry_in,
    output logic [DW-1:0]   result,
    output logic [FW-1:0]   flag_val,
    output logic [FW-1:0]   flag_mask
);

    logic [DW:0] wide;
    logic        carry;
    logic        zn_upd;
    logic        c_upd;

    // Op decode; shifts use a one-bit extension so the last bit shifted
    // out lands in a fixed position regardless of the amount.
    always_comb begin
        wide   = '0;
        result = a;
        carry  = carry_in;
        zn_upd = 1'b1;
        c_upd  = 1'b0;
        unique case (op)
            ALU_NOP:  zn_upd = 1'b0;
            ALU_MOV:  result = b;
            ALU_NOT:  result = ~a;
            ALU_INC: begin
                wide   = {1'b0, a} + {{DW{1'b0}}, 1'b1};
                result = wide[DW-1:0];
                carry  = wide[DW];
                c_upd  = 1'b1;
            end
            ALU_DEC: begin
                result = a - {{(DW-1){1'b0}}, 1'b1};
                carry  = (a == '0);
                c_upd  = 1'b1;
            end
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
                c_upd  = 1'b1;
            end
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
                c_upd  = 1'b1;
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SHL: begin
                wide   = {1'b0, a} << shamt;
                result = wide[DW-1:0];
                carry  = wide[DW];
                c_upd  = (shamt != '0);
            end
            ALU_SHR: begin
                wide   = {a, 1'b0} >> shamt;
                result = wide[DW:1];
                carry  = wide[0];
                c_upd  = (shamt != '0);
            end
            ALU_SETC: begin
                zn_upd = 1'b0;
                carry  = 1'b1;
                c_upd  = 1'b1;
            end
            ALU_CLRC: begin
                zn_upd = 1'b0;
                carry  = 1'b0;
                c_upd  = 1'b1;
            end
            default:  zn_upd = 1'b0;
        endcase
    end

    // Pack candidate flags and their update mask.
    always_comb begin
        flag_val          = '0;
        flag_mask         = '0;
        flag_val[FLAG_Z]  = (result == '0);
        flag_val[FLAG_N]  = result[DW-1];
        flag_val[FLAG_C]  = carry;
        flag_mask[FLAG_Z] = zn_upd;
        flag_mask[FLAG_N] = zn_upd;
        flag_mask[FLAG_C] = c_upd;
    end

endmodule

// File: rtl/var_reg.sv
// Plain width-parameterized register with asynchronous active-high reset.
module var_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d every edge; reset clears immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, CCR ownership, conditional jump
// evaluation and the EX/MEM pipeline buffer.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        alu_op,
    input  logic              alu_src_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [1:0]        fwd_sel_a,
    input  logic [1:0]        fwd_sel_b,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic [DATA_W-1:0] wb_fwd,
    input  logic              flags_write,
    input  logic [1:0]        jump_cond,
    input  logic              flags_restore,
    input  logic [FLAG_W-1:0] flags_restore_value,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] LDM_value,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic              memory_push,
    input  logic              memory_pop,
    input  logic              reg_write,
    input  logic              pc_enable,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic [1:0]        wb_sel,
    output logic              jump_taken,
    output logic [DATA_W-1:0] jump_target,
    output logic [FLAG_W-1:0] flags,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [DATA_W-1:0] LDM_value_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              memory_read_out,
    output logic              memory_write_out,
    output logic              memory_push_out,
    output logic              memory_pop_out,
    output logic              reg_write_out,
    output logic              pc_enable_out,
    output logic [1:0]        memory_address_select_out,
    output logic [1:0]        memory_write_src_select_out,
    output logic [1:0]        wb_sel_out
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res;
    logic [FLAG_W-1:0] ccr, alu_flags, alu_mask, ccr_alu, jump_clear, ccr_next;
    logic              jump_hit;

    // Forwarding muxes; operand B may be replaced by the immediate, but the
    // store data always takes the forwarded register value.
    always_comb begin
        unique case (fwd_sel_t'(fwd_sel_a))
            FWD_MEM: op_a = mem_fwd;
            FWD_WB:  op_a = wb_fwd;
            default: op_a = read_data1;
        endcase
        unique case (fwd_sel_t'(fwd_sel_b))
            FWD_MEM: fwd_b = mem_fwd;
            FWD_WB:  fwd_b = wb_fwd;
            default: fwd_b = read_data2;
        endcase
        op_b = alu_src_imm ? imm : fwd_b;
    end

    execute_stage_alu #(.DW(DATA_W), .FW(FLAG_W), .SH_W(SH_W)) u_alu (
        .a         (op_a),
        .b         (op_b),
        .op        (alu_op_t'(alu_op)),
        .shamt     (imm[SH_W-1:0]),
        .carry_in  (ccr[FLAG_C]),
        .result    (alu_res),
        .flag_val  (alu_flags),
        .flag_mask (alu_mask)
    );

    // Jump test against the registered CCR; a stalled jump never fires.
    always_comb begin
        jump_clear = '0;
        jump_hit   = 1'b0;
        unique case (jump_cond_t'(jump_cond))
            JMP_Z: begin jump_hit = ccr[FLAG_Z]; jump_clear[FLAG_Z] = 1'b1; end
            JMP_N: begin jump_hit = ccr[FLAG_N]; jump_clear[FLAG_N] = 1'b1; end
            JMP_C: begin jump_hit = ccr[FLAG_C]; jump_clear[FLAG_C] = 1'b1; end
            default: ;
        endcase
        jump_taken = jump_hit & ~stall;
        if (!jump_taken) jump_clear = '0;
        jump_target = op_a;
    end

    // Merge ALU flag writes first, then knock out the flag a taken jump tested.
    always_comb begin
        ccr_alu  = flags_write ? ((ccr & ~alu_mask) | (alu_flags & alu_mask)) : ccr;
        ccr_next = ccr_alu & ~jump_clear;
    end

    // CCR: stall holds, an RTI restore overrides any ALU/jump update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              ccr <= '0;
        else if (!stall) begin
            if (flags_restore)  ccr <= flags_restore_value;
            else                ccr <= ccr_next;
        end
    end

    assign flags = ccr;

    // EX/MEM buffer: control is zeroed on a bubble, data simply holds then.
    ex_ctrl_t          ctrl_in, ctrl_q, ctrl_d;
    logic [DATA_W-1:0] res_d, store_d, ldm_d;
    logic [PC_W-1:0]   pc_d;
    logic              data_load;

    assign ctrl_in = '{memory_read, memory_write, memory_push, memory_pop,
                       reg_write, pc_enable, memory_address_select,
                       memory_write_src_select, wb_sel};

    assign data_load = ~stall & ~flush;
    assign ctrl_d    = stall ? ctrl_q : (flush ? '0 : ctrl_in);
    assign res_d     = data_load ? alu_res    : alu_result_out;
    assign store_d   = data_load ? fwd_b      : store_data_out;
    assign ldm_d     = data_load ? LDM_value  : LDM_value_out;
    assign pc_d      = data_load ? pc         : pc_out;

    var_reg #(.WIDTH($bits(ex_ctrl_t))) u_ctrl_reg (.clk(clk), .reset(reset), .d(ctrl_d),  .q(ctrl_q));
    var_reg #(.WIDTH(DATA_W))           u_res_reg  (.clk(clk), .reset(reset), .d(res_d),   .q(alu_result_out));
    var_reg #(.WIDTH(DATA_W))           u_st_reg   (.clk(clk), .reset(reset), .d(store_d), .q(store_data_out));
    var_reg #(.WIDTH(DATA_W))           u_ldm_reg  (.clk(clk), .reset(reset), .d(ldm_d),   .q(LDM_value_out));
    var_reg #(.WIDTH(PC_W))             u_pc_reg   (.clk(clk), .reset(reset), .d(pc_d),    .q(pc_out));

    assign memory_read_out             = ctrl_q.memory_read;
    assign memory_write_out            = ctrl_q.memory_write;
    assign memory_push_out             = ctrl_q.memory_push;
    assign memory_pop_out              = ctrl_q.memory_pop;
    assign reg_write_out               = ctrl_q.reg_write;
    assign pc_enable_out               = ctrl_q.pc_enable;
    assign memory_address_select_out   = ctrl_q.memory_address_select;
    assign memory_write_src_select_out = ctrl_q.memory_write_src_select;
    assign wb_sel_out                  = ctrl_q.wb_sel;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly upstream of the memory stage.
- Selects forwarded operands, runs the 16-bit ALU and owns the 3-bit condition code register (CCR).
- Evaluates conditional jumps.
- Registers ALU result, store data, PC and all memory/write-back control into the EX/MEM buffer that the memory stage consumes.

Parameters:
- DATA_W, 16, operand/result width
- PC_W, 32, program counter width
- FLAG_W, 3, CCR width; bit0 Z, bit1 N, bit2 C

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold EX/MEM buffer and CCR
- flush  in  1  load a bubble into EX/MEM
- alu_op  in  4  operation, encoding in package
- alu_src_imm  in  1  operand B = imm
- imm  in  16  immediate; shift amount = imm[3:0]
- read_data1, read_data2  in  16 each  register file operands
- fwd_sel_a, fwd_sel_b  in  2 each  0 regfile, 1 mem_fwd, 2 wb_fwd, 3 regfile
- mem_fwd, wb_fwd  in  16 each  forwarded results
- flags_write  in  1  ALU op may update CCR
- jump_cond  in  2  0 none, 1 JZ, 2 JN, 3 JC
- flags_restore, flags_restore_value  in  1, 3  RTI pop path
- pc, LDM_value  in  32, 16  passthrough
- memory_read, memory_write, memory_push, memory_pop, reg_write, pc_enable  in  1 each  passthrough
- memory_address_select, memory_write_src_select, wb_sel  in  2 each  passthrough
- jump_taken  out  1  combinational, to fetch
- jump_target  out  16  combinational, forwarded operand A
- flags  out  3  CCR (registered)
- alu_result_out, store_data_out, LDM_value_out  out  16 each  EX/MEM buffer
- pc_out  out  32  EX/MEM buffer
- all passthrough control, suffixed _out, same widths, EX/MEM buffer

Behaviour:
- Reset (async): every buffered output 0; CCR 0.
- Latency: one cycle from input to buffered output.
- Operand A = fwd mux(read_data1). Operand B = imm when alu_src_imm, else fwd mux(read_data2). store_data = fwd mux(read_data2) before the imm select.
- ALU ops:
  - NOP: result = A, no flag change
  - MOV: B
  - NOT: ~A
  - INC: A+1
  - DEC: A-1
  - ADD: A+B
  - SUB: A-B
  - AND, OR
  - SHL, SHR: A shifted by imm[3:0]
  - SETC, CLRC: result A
- Carry (C):
  - ADD/INC: bit 16 of the 17-bit sum.
  - SUB/DEC: borrow (A<B; DEC borrows iff A==0).
  - SHL: last bit shifted out, A[16-sh]. SHR: A[sh-1].
  - Shift amount 0: C unchanged.
  - SETC/CLRC: set/clear C only.
  - NOT/AND/OR/MOV: C unchanged.
- Z/N: updated from result for all arithmetic/logic ops; unchanged for NOP, SETC, CLRC.
- CCR updates only when flags_write=1.
- CCR edge priority, highest first:
  1. reset
  2. stall: hold
  3. flags_restore: load flags_restore_value
  4. ALU update
  5. jump clear
- Jump clear and ALU update in the same cycle merge: the ALU writes its bits, then the tested bit is cleared.
- Flush does not block CCR writes from an instruction already in EX.
- jump_taken = (cond==JZ & Z) | (cond==JN & N) | (cond==JC & C), using the registered CCR. Forced to 0 while stall.
- On a taken jump, the tested flag is cleared at the next edge.
- EX/MEM buffer:
  - stall=1: all buffered outputs hold.
  - else flush=1: all control _out = 0; data _out keep their loaded values (don't-care).
  - else: load.
  - stall has priority over flush.
- Widths: all arithmetic is modulo 2^16; no saturation.

Decomposition:
- Shared package (processor-wide pkg):
  - alu_op enum and fwd_sel encodings
  - jump_cond encodings
  - flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2)
- One sub-module: alu (combinational, operands + op + carry_in -> result + flag vector + per-flag update mask).
- EX/MEM buffer built from existing var_reg instances; the stall enable and flush zeroing are added in this stage.

Test Plan:
- ADD A=0xFFFF, B=0x0001, flags_write=1 -> alu_result_out=0x0000 next cycle; flags=3'b101 (C,Z).
- SUB A=0x0003 via fwd_sel_a=1 (mem_fwd=0x0003), imm=0x0005, alu_src_imm=1 -> result 0xFFFE, flags=3'b110 (C borrow, N).
- SHL A=0x8001, imm=1 -> result 0x0002, C=1. Then SHL imm=0 -> result unchanged, C stays 1.
- CCR Z=1; jump_cond=JZ, read_data1=0x0040 -> jump_taken=1, jump_target=0x0040 same cycle; Z=0 next cycle. With stall=1 -> jump_taken=0 and Z held.
- reg_write=1, memory_write=1 with stall=1 for 2 cycles, then flush=1 -> outputs hold the prior values for 2 cycles, then reg_write_out=memory_write_out=0. Stall and flush together -> hold wins.
- flags_restore=1, value 3'b011, with flags_write=1 on the same edge -> flags=3'b011. Assert reset mid-stream -> all outputs 0 immediately (asynchronous).
